// File: rtl/if_stage_pkg.sv
// Shared datapath constants and helpers for the instruction-fetch stage.
// - INS_WIDTH    : instruction / address width
// - PC_STEP      : sequential PC increment (one word)
// - RESET_PC_DEF : default PC after reset
// - NOP_INS_DEF  : default bubble word placed in IF/ID (sll $0,$0,0)
// - pc_sel_e     : next-PC source chosen by the per-cycle priority mux
package if_stage_pkg;

  localparam int unsigned INS_WIDTH = 32;
  localparam logic [INS_WIDTH-1:0] PC_STEP      = 32'd4;
  localparam logic [INS_WIDTH-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [INS_WIDTH-1:0] NOP_INS_DEF  = 32'h0000_0000;

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'd0,
    SEL_BRANCH = 2'd1,
    SEL_JUMP   = 2'd2,
    SEL_HOLD   = 2'd3
  } pc_sel_e;

  // Force an address onto a word boundary; low two bits of targets are ignored.
  function automatic logic [INS_WIDTH-1:0] word_align(input logic [INS_WIDTH-1:0] a);
    return a & ~(PC_STEP - 32'd1);
  endfunction

endpackage

// File: rtl/if_stage_pc_reg.sv
// Program-counter register with synchronous reset, load and hold.
// The next-PC selection lives in the parent; this block only stores.
// Ports:
// - clk   in  1   rising-edge clock
// - rst   in  1   synchronous active-high reset, loads RESET_PC
// - load  in  1   1: capture pc_d, 0: hold
// - pc_d  in  32  next PC (word aligned by this block)
// - pc_q  out 32  current PC
module if_stage_pc_reg
  import if_stage_pkg::*;
#(
  parameter logic [INS_WIDTH-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [INS_WIDTH-1:0] pc_d,
  output logic [INS_WIDTH-1:0] pc_q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= word_align(RESET_PC);
    end else if (load) begin
      pc_q <= word_align(pc_d);
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline.
// Holds the PC, presents it to instruction memory, and latches the fetched
// word into the IF/ID register. Handles sequential fetch, branch/jump
// redirect with IF/ID flush, and hazard stall.
// Ports:
// - clk, rst              clock, synchronous active-high reset
// - stall                 hold PC and IF/ID this cycle
// - br_taken, br_target   branch redirect (highest priority after reset)
// - jump, jump_target     jump redirect
// - imem_addr             instruction-memory address (= PC register)
// - imem_rdata            instruction word at imem_addr, same cycle
// - ID_ins, ID_pc4        IF/ID instruction and its PC+4
// - ID_valid              IF/ID holds a real instruction (0 = bubble)
// - fetch_count           instructions latched into IF/ID with ID_valid=1
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [INS_WIDTH-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [INS_WIDTH-1:0] NOP_INS  = NOP_INS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 br_taken,
  input  logic [INS_WIDTH-1:0] br_target,
  input  logic                 jump,
  input  logic [INS_WIDTH-1:0] jump_target,
  output logic [INS_WIDTH-1:0] imem_addr,
  input  logic [INS_WIDTH-1:0] imem_rdata,
  output logic [INS_WIDTH-1:0] ID_ins,
  output logic [INS_WIDTH-1:0] ID_pc4,
  output logic                 ID_valid,
  output logic [INS_WIDTH-1:0] fetch_count
);

  pc_sel_e              sel;
  logic [INS_WIDTH-1:0] pc_q;
  logic [INS_WIDTH-1:0] pc_d;
  logic [INS_WIDTH-1:0] pc_plus4;
  logic                 pc_load;

  logic [INS_WIDTH-1:0] ins_q, ins_d;
  logic [INS_WIDTH-1:0] pc4_q, pc4_d;
  logic                 valid_q, valid_d;
  logic [INS_WIDTH-1:0] count_q, count_d;

  // Wraps modulo 2^32 naturally.
  assign pc_plus4 = pc_q + PC_STEP;

  // Branch beats jump (it belongs to the older instruction); any redirect beats stall.
  always_comb begin
    sel = SEL_SEQ;
    if (br_taken) begin
      sel = SEL_BRANCH;
    end else if (jump) begin
      sel = SEL_JUMP;
    end else if (stall) begin
      sel = SEL_HOLD;
    end
  end

  always_comb begin
    pc_d    = pc_plus4;
    pc_load = 1'b1;
    ins_d   = ins_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    count_d = count_q;
    unique case (sel)
      SEL_BRANCH, SEL_JUMP: begin
        pc_d    = (sel == SEL_BRANCH) ? br_target : jump_target;
        ins_d   = NOP_INS;
        pc4_d   = '0;
        valid_d = 1'b0;
      end
      SEL_HOLD: begin
        pc_load = 1'b0;
      end
      default: begin
        ins_d   = imem_rdata;
        pc4_d   = pc_plus4;
        valid_d = 1'b1;
        count_d = count_q + 32'd1;
      end
    endcase
  end

  if_stage_pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk (clk),
    .rst (rst),
    .load(pc_load),
    .pc_d(pc_d),
    .pc_q(pc_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ins_q   <= NOP_INS;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      ins_q   <= ins_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign ID_ins      = ins_q;
  assign ID_pc4      = pc4_q;
  assign ID_valid    = valid_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: each stimulus cycle pushes the expected
// post-edge state from a behavioural model; a monitor pops and compares.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] ID_ins;
  logic [31:0] ID_pc4;
  logic        ID_valid;
  logic [31:0] fetch_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] ins;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  // Reference state
  logic [31:0] m_pc, m_ins, m_pc4, m_cnt;
  logic        m_valid;

  if_stage #(
    .RESET_PC(32'h0000_0000),
    .NOP_INS (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jump       (jump),
    .jump_target(jump_target),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .ID_ins     (ID_ins),
    .ID_pc4     (ID_pc4),
    .ID_valid   (ID_valid),
    .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: two known words then a hash of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2001_0005;
    if (a == 32'h4) return 32'h2002_0007;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // One cycle of stimulus; model the architectural effect of that edge.
  task automatic cyc(input logic r, input logic s, input logic b, input logic [31:0] bt,
                     input logic j, input logic [31:0] jt);
    exp_t e;
    rst = r; stall = s; br_taken = b; br_target = bt; jump = j; jump_target = jt;
    if (r) begin
      m_pc = 32'h0; m_ins = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_cnt = 32'h0;
    end else if (b || j) begin
      m_pc = {(b ? bt[31:2] : jt[31:2]), 2'b00};
      m_ins = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    end else if (!s) begin
      m_ins = mem_word(m_pc);
      m_pc4 = m_pc + 32'd4;
      m_pc = m_pc + 32'd4;
      m_valid = 1'b1;
      m_cnt = m_cnt + 32'd1;
    end
    e.addr = m_pc; e.ins = m_ins; e.pc4 = m_pc4; e.valid = m_valid; e.cnt = m_cnt;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic norm();
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Monitor: compare DUT state a little after each rising edge.
  always @(posedge clk) begin
    #2;
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("imem_addr",   imem_addr,   e.addr);
      chk("ID_ins",      ID_ins,      e.ins);
      chk("ID_pc4",      ID_pc4,      e.pc4);
      chk("ID_valid",    {31'b0, ID_valid}, {31'b0, e.valid});
      chk("fetch_count", fetch_count, e.cnt);
    end
  end

  initial begin
    logic [31:0] t1, t2;
    int unsigned roll;
    rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = '0; jump = 1'b0; jump_target = '0;
    m_pc = '0; m_ins = '0; m_pc4 = '0; m_valid = 1'b0; m_cnt = '0;

    // Reset held two cycles
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    // Sequential fetch of @0 and @4
    norm(); norm();
    // Stall at PC=8 for three cycles, then release
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    norm();
    // Branch and jump together: branch wins
    cyc(1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 32'h80);
    norm(); norm();
    // Redirect during stall, misaligned target
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0103);
    norm();
    // Wrap from 0xFFFF_FFFC to 0
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    norm(); norm();
    // Reset while stalled, then fetch from RESET_PC
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    norm(); norm();
    // Reset while redirecting
    cyc(1'b1, 1'b0, 1'b1, 32'h1234, 1'b1, 32'h5678);
    norm();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      roll = $urandom_range(0, 99);
      t1 = $urandom;
      t2 = $urandom;
      if ($urandom_range(0, 7) == 0) t1 = 32'hFFFF_FFF0 | (t1 & 32'hF);
      cyc(roll < 2, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, t1,
          $urandom_range(0, 9) == 0, t2);
    end
    norm();

    // Allow the monitor to drain, then confirm every expectation was consumed.
    @(posedge clk);
    #4;
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
